// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/RAS status outputs of the fetch-stage sequencer
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             branch;
  logic             jump;
  logic             call;
  logic             ret;
  logic             exc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;
  modport master (output stall, branch, jump, call, ret, exc, target,
                  input pc, epc, ras_empty, ras_full);
  modport slave  (input stall, branch, jump, call, ret, exc, target,
                  output pc, epc, ras_empty, ras_full);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with stall, exception redirect/EPC capture and a circular return-address stack
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
  parameter int               RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int               AW   = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);
  localparam logic [WIDTH-1:0] MASK = ~WIDTH'(INC - 1);
  localparam logic [AW:0]      FULL = (AW+1)'(RAS_DEPTH);
  logic [WIDTH-1:0] pc_q, epc_q, pc_n, seq, tgt, top;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW:0]      count;
  logic             push, pop, have;
  always_comb begin
    seq  = pc_q + STEP;
    tgt  = bus.target & MASK;
    top  = ras[ptr - AW'(1)];
    have = count != '0;
    pop  = !bus.exc && bus.ret && have;
    push = !bus.exc && !bus.ret && bus.jump && bus.call;
    pc_n = bus.exc                ? EXC_VECTOR :
           bus.ret                ? (have ? top : tgt) :
           bus.branch || bus.jump ? tgt :
           bus.stall              ? pc_q : seq;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      pc_q <= pc_n;
      if (bus.exc) epc_q <= pc_q;
      if (push) begin
        ptr   <= ptr + AW'(1);
        count <= count == FULL ? FULL : count + (AW+1)'(1);
      end else if (pop) begin
        ptr   <= ptr - AW'(1);
        count <= count - (AW+1)'(1);
      end
    end
  end
  // entries are only read while count>0, so they need no reset; a full push overwrites the oldest
  always_ff @(posedge clk) if (push) ras[ptr] <= seq;
  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.ras_empty = count == '0;
  assign bus.ras_full  = count == FULL;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table, directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  pc_sequencer_if #(.WIDTH(32)) u ();
  pc_sequencer_if #(.WIDTH(8))  u8 ();
  pc_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(u));
  pc_sequencer #(.WIDTH(8), .EXC_VECTOR(8'h80)) dut8 (.clk(clk), .rst(rst), .bus(u8));
  int n_err = 0;
  int n_chk = 0;
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras [$];
  typedef struct {
    logic s, b, j, c, r, e;
    logic [31:0] t, pc, epc;
    logic emp, full;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_step(input logic s, b, j, c, r, e, input logic [31:0] t);
    if (e) begin
      m_epc = m_pc;
      m_pc  = 32'h80;
    end else if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = t & ~32'd3;
    end else if (b || j) begin
      if (j && c) begin
        m_ras.push_back(m_pc + 4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = t & ~32'd3;
    end else if (!s) m_pc = m_pc + 4;
  endtask
  task automatic apply(input logic s, b, j, c, r, e, input logic [31:0] t);
    u.stall = s; u.branch = b; u.jump = j; u.call = c; u.ret = r; u.exc = e; u.target = t;
    @(posedge clk);
    model_step(s, b, j, c, r, e, t);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    u.stall = 0; u.branch = 0; u.jump = 0; u.call = 0; u.ret = 0; u.exc = 0; u.target = 0;
    rst = 1; #3; rst = 0;
    m_pc = 0; m_epc = 0; m_ras.delete();
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, u.pc, m_pc);
    chk({tag, ".epc"}, u.epc, m_epc);
    chk({tag, ".empty"}, u.ras_empty, m_ras.size() == 0);
    chk({tag, ".full"}, u.ras_full, m_ras.size() == 4);
  endtask
  initial begin
    u.stall = 0; u.branch = 0; u.jump = 0; u.call = 0; u.ret = 0; u.exc = 0; u.target = 0;
    u8.stall = 0; u8.branch = 0; u8.jump = 0; u8.call = 0; u8.ret = 0; u8.exc = 0; u8.target = 0;
    tbl[0]  = '{0,0,0,0,0,0, 32'h0,   32'h4,   32'h0,   1, 0};
    tbl[1]  = '{0,0,0,0,0,0, 32'h0,   32'h8,   32'h0,   1, 0};
    tbl[2]  = '{1,0,0,0,0,0, 32'h0,   32'h8,   32'h0,   1, 0};
    tbl[3]  = '{1,0,0,0,0,0, 32'h0,   32'h8,   32'h0,   1, 0};
    tbl[4]  = '{1,1,0,0,0,0, 32'h40,  32'h40,  32'h0,   1, 0};
    tbl[5]  = '{0,0,0,0,0,0, 32'h0,   32'h44,  32'h0,   1, 0};
    tbl[6]  = '{0,1,0,0,0,0, 32'h22,  32'h20,  32'h0,   1, 0};
    tbl[7]  = '{0,0,1,1,0,0, 32'h100, 32'h100, 32'h0,   0, 0};
    tbl[8]  = '{0,0,0,0,1,0, 32'h0,   32'h24,  32'h0,   1, 0};
    tbl[9]  = '{0,0,0,0,1,0, 32'h203, 32'h200, 32'h0,   1, 0};
    tbl[10] = '{0,1,0,1,0,0, 32'h300, 32'h300, 32'h0,   1, 0};
    tbl[11] = '{0,0,0,1,0,0, 32'h0,   32'h304, 32'h0,   1, 0};
    tbl[12] = '{0,0,1,1,1,1, 32'h500, 32'h80,  32'h304, 1, 0};
    tbl[13] = '{0,0,0,0,0,1, 32'h0,   32'h80,  32'h80,  1, 0};
    tbl[14] = '{1,0,1,0,0,0, 32'h7,   32'h4,   32'h80,  1, 0};
    tbl[15] = '{0,0,0,0,0,0, 32'h0,   32'h8,   32'h80,  1, 0};
    #2 rst = 0;
    do_reset();
    chk("reset.pc", u.pc, 32'h0);
    chk("reset.epc", u.epc, 32'h0);
    chk("reset.empty", u.ras_empty, 1'b1);
    chk("reset.full", u.ras_full, 1'b0);
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].e, tbl[i].t);
      chk($sformatf("tbl%0d.pc", i), u.pc, tbl[i].pc);
      chk($sformatf("tbl%0d.epc", i), u.epc, tbl[i].epc);
      chk($sformatf("tbl%0d.empty", i), u.ras_empty, tbl[i].emp);
      chk($sformatf("tbl%0d.full", i), u.ras_full, tbl[i].full);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 1, 0, 0, 32'h10 * (i + 1));
      chk($sformatf("call%0d.pc", i), u.pc, 32'h10 * (i + 1));
      chk($sformatf("call%0d.full", i), u.ras_full, i >= 3);
    end
    apply(0, 0, 1, 1, 1, 1, 32'h999);
    chk("exc.pc", u.pc, 32'h80);
    chk("exc.epc", u.epc, 32'h50);
    chk("exc.full", u.ras_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 1, 0, 32'h0);
      chk($sformatf("ret%0d.pc", i), u.pc, 32'h44 - 32'h10 * i);
      chk($sformatf("ret%0d.full", i), u.ras_full, 1'b0);
    end
    chk("ret_all.empty", u.ras_empty, 1'b1);
    apply(0, 0, 0, 0, 1, 0, 32'h200);
    chk("ret_empty.pc", u.pc, 32'h200);
    chk("ret_empty.epc", u.epc, 32'h50);
    apply(0, 0, 1, 1, 0, 0, 32'h700);
    #2 rst = 1; #1;
    chk("async.pc", u.pc, 32'h0);
    chk("async.empty", u.ras_empty, 1'b1);
    #1 rst = 0;
    m_pc = 0; m_epc = 0; m_ras.delete();
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 32'h0);
      chk($sformatf("idle%0d.pc", i), u.pc, 32'd4 * i);
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      apply(r[0], $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, r[1],
            $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0, $urandom);
      chk_model($sformatf("rnd%0d", i));
    end
    u8.branch = 1; u8.target = 8'hFC;
    @(posedge clk); #1;
    u8.branch = 0;
    chk("w8.load", 32'(u8.pc), 32'hFC);
    @(posedge clk); #1;
    chk("w8.wrap", 32'(u8.pc), 32'h00);
    u8.branch = 1; u8.target = 8'h13;
    @(posedge clk); #1;
    u8.branch = 0;
    chk("w8.align", 32'(u8.pc), 32'h10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
